// File: rtl/bnn_cmd_if.sv
// Handshake and bus bundle between the command controller, SPI byte receiver,
// image buffer and BNN core.
interface bnn_cmd_if #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7,
    parameter int RESULT_W = 4
);
    logic [DATA_W-1:0]   rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_load;
    logic [3:0]          status_code;
    logic                buf_wr_en;
    logic [ADDR_W-1:0]   buf_wr_addr;
    logic [DATA_W-1:0]   buf_wr_data;
    logic                buf_wr_ready;
    logic                buf_clear;
    logic                buf_empty;
    logic                bnn_start;
    logic                result_valid;
    logic [RESULT_W-1:0] result_class;

    modport master (
        input  rx_data, rx_valid, buf_wr_ready, buf_empty, result_valid, result_class,
        output rx_ready, tx_data, tx_load, status_code, buf_wr_en, buf_wr_addr,
               buf_wr_data, buf_clear, bnn_start
    );

    modport slave (
        output rx_data, rx_valid, buf_wr_ready, buf_empty, result_valid, result_class,
        input  rx_ready, tx_data, tx_load, status_code, buf_wr_en, buf_wr_addr,
               buf_wr_data, buf_clear, bnn_start
    );
endinterface

// File: rtl/bnn_cmd_controller.sv
// Command/sequencing FSM: decodes host bytes, streams an image into the buffer,
// starts the BNN and returns its class result on request.
module bnn_cmd_controller #(
    parameter int                DATA_W         = 8,
    parameter int                IMG_BYTES      = 113,
    parameter int                ADDR_W         = $clog2(IMG_BYTES),
    parameter int                RESULT_W       = 4,
    parameter int                TIMEOUT_CYCLES = 65535,
    parameter logic [DATA_W-1:0] CMD_IMG        = 'hFE,
    parameter logic [DATA_W-1:0] CMD_CLEAR      = 'hFD,
    parameter logic [DATA_W-1:0] CMD_READ       = 'hFC
) (
    input  logic     clk,
    input  logic     rst_n,
    bnn_cmd_if.master bus
);
    localparam int TCNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int TMAX   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    localparam logic [3:0] ST_IDLE   = 4'h0;
    localparam logic [3:0] ST_RXRDY  = 4'h1;
    localparam logic [3:0] ST_RXIMG  = 4'h2;
    localparam logic [3:0] ST_BUSY   = 4'h4;
    localparam logic [3:0] ST_RESULT = 4'h8;
    localparam logic [3:0] ST_ERROR  = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IMG, S_RX_IMG, S_BNN_RUN, S_RESULT, S_ERROR, S_CLEAR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [3:0]          status_q, status_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_load_q, tx_load_d;
    logic                bnn_start_q, bnn_start_d;

    logic in_img;
    logic rx_ready;
    logic accept;
    logic last_byte;
    logic timeout_hit;

    // Image states throttle the receiver with the buffer's write readiness.
    always_comb begin
        in_img = (state_q == S_WAIT_IMG) || (state_q == S_RX_IMG);
        case (state_q)
            S_WAIT_IMG, S_RX_IMG: rx_ready = bus.buf_wr_ready;
            S_CLEAR:              rx_ready = 1'b0;
            default:              rx_ready = 1'b1;
        endcase
        accept      = bus.rx_valid && rx_ready;
        last_byte   = (cnt_q == ADDR_W'(IMG_BYTES - 1));
        timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == TCNT_W'(TMAX));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        result_d    = result_q;
        status_d    = status_q;
        tx_data_d   = tx_data_q;
        tx_load_d   = 1'b0;
        bnn_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.rx_data == CMD_IMG) begin
                        state_d  = S_WAIT_IMG;
                        cnt_d    = '0;
                        tcnt_d   = '0;
                        status_d = ST_RXRDY;
                    end else if (bus.rx_data == CMD_CLEAR) begin
                        state_d  = S_CLEAR;
                        result_d = '0;
                        status_d = ST_IDLE;
                    end else begin
                        status_d = ST_ERROR;
                    end
                end
            end
            // Every byte here is payload, including values matching command codes.
            S_WAIT_IMG, S_RX_IMG: begin
                if (accept) begin
                    tcnt_d = '0;
                    if (last_byte) begin
                        state_d     = S_BNN_RUN;
                        status_d    = ST_BUSY;
                        bnn_start_d = 1'b1;
                    end else begin
                        cnt_d    = cnt_q + 1'b1;
                        state_d  = S_RX_IMG;
                        status_d = ST_RXIMG;
                    end
                end else if (timeout_hit) begin
                    state_d  = S_ERROR;
                    status_d = ST_ERROR;
                end else if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_BNN_RUN: begin
                if (accept && (bus.rx_data == CMD_CLEAR)) begin
                    state_d  = S_CLEAR;
                    result_d = '0;
                    status_d = ST_IDLE;
                end else if (bus.result_valid) begin
                    result_d = bus.result_class;
                    state_d  = S_RESULT;
                    status_d = ST_RESULT;
                end
            end
            S_RESULT: begin
                if (accept && (bus.rx_data == CMD_READ)) begin
                    tx_data_d = DATA_W'(result_q);
                    tx_load_d = 1'b1;
                end else if (accept && (bus.rx_data == CMD_CLEAR)) begin
                    state_d  = S_CLEAR;
                    result_d = '0;
                    status_d = ST_IDLE;
                end
            end
            S_ERROR: begin
                if (accept && (bus.rx_data == CMD_CLEAR)) begin
                    state_d  = S_CLEAR;
                    result_d = '0;
                    status_d = ST_IDLE;
                end
            end
            S_CLEAR: begin
                result_d = '0;
                if (bus.buf_empty) begin
                    state_d  = S_IDLE;
                    status_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                status_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            result_q    <= '0;
            status_q    <= ST_IDLE;
            tx_data_q   <= '0;
            tx_load_q   <= 1'b0;
            bnn_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            result_q    <= result_d;
            status_q    <= status_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            bnn_start_q <= bnn_start_d;
        end
    end

    assign bus.rx_ready    = rx_ready;
    assign bus.buf_wr_en   = in_img && accept;
    assign bus.buf_wr_addr = in_img ? cnt_q : '0;
    assign bus.buf_wr_data = in_img ? bus.rx_data : '0;
    assign bus.buf_clear   = (state_q == S_CLEAR);
    assign bus.status_code = status_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_load     = tx_load_q;
    assign bus.bnn_start   = bnn_start_q;
endmodule

// File: tb/tb_bnn_cmd_controller.sv
// Directed bench for bnn_cmd_controller with a 4-byte image and an 8-cycle timeout.
module tb_bnn_cmd_controller;
    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int start_count = 0;
    int txload_count = 0;
    logic [7:0] mem [0:3];

    always #5 clk = ~clk;

    bnn_cmd_if #(.DATA_W(8), .ADDR_W(2), .RESULT_W(4)) bus ();

    bnn_cmd_controller #(
        .DATA_W(8), .IMG_BYTES(4), .ADDR_W(2), .RESULT_W(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always @(posedge clk) begin
        if (bus.buf_wr_en) begin
            mem[bus.buf_wr_addr] = bus.buf_wr_data;
            wr_count++;
        end
        if (bus.bnn_start) start_count++;
        if (bus.tx_load) txload_count++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte for a single cycle; caller guarantees rx_ready.
    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        $display("txn byte %h -> status %h", b, bus.status_code);
    endtask

    task automatic img_byte(input logic [7:0] b, input logic [1:0] a);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        #1;
        check_val("wr_en", 32'(bus.buf_wr_en), 32'd1);
        check_val("wr_addr", 32'(bus.buf_wr_addr), 32'(a));
        check_val("wr_data", 32'(bus.buf_wr_data), 32'(b));
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        $display("txn img byte %h addr %0d -> status %h", b, a, bus.status_code);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.rx_data       = '0;
        bus.rx_valid      = 1'b0;
        bus.buf_wr_ready  = 1'b1;
        bus.buf_empty     = 1'b1;
        bus.result_valid  = 1'b0;
        bus.result_class  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_status", 32'(bus.status_code), 32'h0);
        check_val("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check_val("rst_tx_load", 32'(bus.tx_load), 32'd0);
        check_val("rst_tx_data", 32'(bus.tx_data), 32'h0);
        check_val("rst_start", 32'(bus.bnn_start), 32'd0);
        check_val("rst_clear", 32'(bus.buf_clear), 32'd0);
        check_val("rst_wr_en", 32'(bus.buf_wr_en), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Image with command-valued payload bytes and a mid-image stall
        send(8'hFE);
        check_val("img_status1", 32'(bus.status_code), 32'h1);
        img_byte(8'h11, 2'd0);
        check_val("img_status2", 32'(bus.status_code), 32'h2);
        img_byte(8'hFD, 2'd1);
        bus.buf_wr_ready = 1'b0;
        bus.rx_data      = 8'hFE;
        bus.rx_valid     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("stall_rx_ready", 32'(bus.rx_ready), 32'd0);
            check_val("stall_wr_en", 32'(bus.buf_wr_en), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        bus.buf_wr_ready = 1'b1;
        img_byte(8'hFE, 2'd2);
        check_val("img_status_mid", 32'(bus.status_code), 32'h2);
        check_val("img_no_start", 32'(bus.bnn_start), 32'd0);
        img_byte(8'h22, 2'd3);
        check_val("img_status4", 32'(bus.status_code), 32'h4);
        check_val("start_pulse", 32'(bus.bnn_start), 32'd1);
        @(negedge clk);
        check_val("start_low", 32'(bus.bnn_start), 32'd0);
        check_val("start_count", 32'(start_count), 32'd1);
        check_val("wr_count", 32'(wr_count), 32'd4);
        check_val("mem0", 32'(mem[0]), 32'h11);
        check_val("mem1", 32'(mem[1]), 32'hFD);
        check_val("mem2", 32'(mem[2]), 32'hFE);
        check_val("mem3", 32'(mem[3]), 32'h22);

        // Result capture and repeated read
        bus.result_class = 4'd7;
        bus.result_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.result_valid = 1'b0;
        check_val("res_status", 32'(bus.status_code), 32'h8);
        send(8'hFC);
        check_val("rd1_load", 32'(bus.tx_load), 32'd1);
        check_val("rd1_data", 32'(bus.tx_data), 32'h07);
        @(negedge clk);
        check_val("rd1_load_low", 32'(bus.tx_load), 32'd0);
        send(8'hFC);
        check_val("rd2_load", 32'(bus.tx_load), 32'd1);
        check_val("rd2_data", 32'(bus.tx_data), 32'h07);
        @(negedge clk);
        check_val("tx_count", 32'(txload_count), 32'd2);

        // Clear holds until the buffer reports empty
        bus.buf_empty = 1'b0;
        send(8'hFD);
        check_val("clr_status", 32'(bus.status_code), 32'h0);
        check_val("clr_buf_clear", 32'(bus.buf_clear), 32'd1);
        check_val("clr_rx_ready", 32'(bus.rx_ready), 32'd0);
        @(negedge clk);
        check_val("clr_hold", 32'(bus.buf_clear), 32'd1);
        bus.buf_empty = 1'b1;
        @(negedge clk);
        check_val("clr_done", 32'(bus.buf_clear), 32'd0);
        check_val("clr_idle_ready", 32'(bus.rx_ready), 32'd1);

        // Inter-byte timeout
        send(8'hFE);
        img_byte(8'hA5, 2'd0);
        repeat (7) @(negedge clk);
        check_val("to_before", 32'(bus.status_code), 32'h2);
        @(negedge clk);
        check_val("to_error", 32'(bus.status_code), 32'hE);
        check_val("to_rx_ready", 32'(bus.rx_ready), 32'd1);
        send(8'h55);
        check_val("err_ignore", 32'(bus.status_code), 32'hE);
        send(8'hFD);
        check_val("err_clear_status", 32'(bus.status_code), 32'h0);
        check_val("err_clear_buf", 32'(bus.buf_clear), 32'd1);
        @(negedge clk);
        check_val("err_back_idle", 32'(bus.buf_clear), 32'd0);

        // Clear wins over simultaneous result_valid
        send(8'hFE);
        img_byte(8'h01, 2'd0);
        img_byte(8'h02, 2'd1);
        img_byte(8'h03, 2'd2);
        img_byte(8'h04, 2'd3);
        check_val("col_busy", 32'(bus.status_code), 32'h4);
        bus.buf_empty    = 1'b0;
        bus.result_class = 4'd9;
        bus.result_valid = 1'b1;
        bus.rx_data      = 8'hFD;
        bus.rx_valid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid     = 1'b0;
        bus.result_valid = 1'b0;
        $display("txn byte fd with result_valid -> status %h", bus.status_code);
        check_val("col_status", 32'(bus.status_code), 32'h0);
        check_val("col_buf_clear", 32'(bus.buf_clear), 32'd1);
        @(negedge clk);
        check_val("col_hold", 32'(bus.buf_clear), 32'd1);
        bus.buf_empty = 1'b1;
        @(negedge clk);
        check_val("col_done", 32'(bus.buf_clear), 32'd0);

        // Bad byte in IDLE, then reset in the middle of an image
        send(8'h33);
        check_val("bad_status", 32'(bus.status_code), 32'hE);
        check_val("bad_rx_ready", 32'(bus.rx_ready), 32'd1);
        send(8'hFE);
        check_val("bad_then_img", 32'(bus.status_code), 32'h1);
        img_byte(8'h44, 2'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("mid_rst_status", 32'(bus.status_code), 32'h0);
        check_val("mid_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check_val("mid_rst_wr_addr", 32'(bus.buf_wr_addr), 32'd0);
        check_val("mid_rst_tx_data", 32'(bus.tx_data), 32'h0);
        check_val("mid_rst_clear", 32'(bus.buf_clear), 32'd0);
        send(8'hFE);
        check_val("post_rst_img", 32'(bus.status_code), 32'h1);
        img_byte(8'h66, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
